invaders_video_fetch: RTL

Raster timing and video-RAM fetch stage downstream of `invaders_memory`. It generates the 256x224 raster counters, syncs and blanks, and steals the work-RAM port once per 8 pixels. It serialises each fetched byte into 1-bit pixels and raises the two per-frame CPU interrupt requests (RST 08 mid-screen, RST 10 end-of-screen). It drives the RAM address mux select and consumes `Ram_out`.

---
 rtl/invaders_video_fetch_if.sv | 23 ++
 rtl/invaders_video_fetch.sv | 62 ++++++
 2 files changed

// File: rtl/invaders_video_fetch_if.sv
// invaders_video_fetch_if: work-RAM fetch, raster timing, pixel and interrupt signals of the video stage.
interface invaders_video_fetch_if;
    logic        Pix_Ce;
    logic [7:0]  Ram_out;
    logic [12:0] Vid_Addr;
    logic        Vid_Sel;
    logic        Video;
    logic        HBlank;
    logic        VBlank;
    logic        HSync;
    logic        VSync;
    logic        Irq_Req;
    logic [7:0]  Irq_Vec;
    logic        Irq_Ack;
    modport master (
        input  Pix_Ce, Ram_out, Irq_Ack,
        output Vid_Addr, Vid_Sel, Video, HBlank, VBlank, HSync, VSync, Irq_Req, Irq_Vec
    );
    modport slave (
        output Pix_Ce, Ram_out, Irq_Ack,
        input  Vid_Addr, Vid_Sel, Video, HBlank, VBlank, HSync, VSync, Irq_Req, Irq_Vec
    );
endinterface

// File: rtl/invaders_video_fetch.sv
// invaders_video_fetch: 256x224 raster timing, one work-RAM byte fetch per 8 pixels,
// 1-bit pixel serialiser and the mid/end-of-screen RST interrupt requests.
module invaders_video_fetch #(
    parameter int          H_TOTAL   = 320,
    parameter int          V_TOTAL   = 262,
    parameter logic [12:0] VRAM_BASE = 13'h0400
) (
    input  logic Clock,
    input  logic Reset,
    invaders_video_fetch_if.master bus
);
    logic [8:0] h, v;
    logic [7:0] hold, shifter;
    logic       fetch, active, h_last, irq_evt;
    always_comb begin
        fetch   = !h[8] && h[2:0] == 3'd0 && v < 9'd224;
        active  = h >= 9'd8 && h <= 9'd263 && v < 9'd224;
        h_last  = h == 9'(H_TOTAL - 1);
        irq_evt = bus.Pix_Ce && h == 9'd0 && (v == 9'd96 || v == 9'd224);
    end
    // Outputs reflect the pixel position seen at the Pix_Ce edge that produced them.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            h            <= '0;
            v            <= '0;
            hold         <= '0;
            shifter      <= '0;
            bus.Vid_Addr <= '0;
            bus.Vid_Sel  <= 1'b0;
            bus.Video    <= 1'b0;
            bus.HBlank   <= 1'b1;
            bus.VBlank   <= 1'b0;
            bus.HSync    <= 1'b0;
            bus.VSync    <= 1'b0;
            bus.Irq_Req  <= 1'b0;
            bus.Irq_Vec  <= 8'hCF;
        end else begin
            if (bus.Pix_Ce) begin
                h <= h_last ? '0 : h + 9'd1;
                if (h_last)
                    v <= (v == 9'(V_TOTAL - 1)) ? '0 : v + 9'd1;
                bus.Vid_Sel <= fetch;
                if (fetch)
                    bus.Vid_Addr <= VRAM_BASE + {v[7:0], h[7:3]};
                // Vid_Sel still high means this edge ends a fetch, so Ram_out holds its byte.
                if (bus.Vid_Sel)
                    hold <= bus.Ram_out;
                shifter    <= (h[2:0] == 3'd7) ? hold : {1'b0, shifter[7:1]};
                bus.Video  <= shifter[0] & active;
                bus.HBlank <= !(h >= 9'd8 && h <= 9'd263);
                bus.VBlank <= v >= 9'd224;
                bus.HSync  <= h >= 9'd272 && h <= 9'd295;
                bus.VSync  <= v >= 9'd234 && v <= 9'd237;
            end
            if (irq_evt) begin
                bus.Irq_Req <= 1'b1;
                bus.Irq_Vec <= (v == 9'd96) ? 8'hCF : 8'hD7;
            end else if (bus.Irq_Ack)
                bus.Irq_Req <= 1'b0;
        end
    end
endmodule
